shift_scheduler: RTL and testbench

SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

---
 rtl/shift_scheduler.sv | 119 +++++++++++
 tb/tb_shift_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_scheduler.sv
// shift_scheduler: two requesters share one logical shifter, round-robin granted.
// Define SHIFT_SCHEDULER_BARREL_EN to do the whole shift on the accepting edge.
module shift_scheduler #(
    parameter int MemoryElementWidth = 12
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [MemoryElementWidth-1:0] req0_value,
    input  logic [MemoryElementWidth-1:0] req0_amount,
    input  logic                          req0_right,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [MemoryElementWidth-1:0] req1_value,
    input  logic [MemoryElementWidth-1:0] req1_amount,
    input  logic                          req1_right,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [MemoryElementWidth-1:0] res_value,
    output logic                          res_owner,
    output logic                          busy
);
    localparam int W = MemoryElementWidth;
    localparam logic [W-1:0] WMAX = W'(W);
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t       state, state_n;
    logic [W-1:0] acc, acc_n;
    logic [W-1:0] count, count_n;
    logic         dir, dir_n;
    logic         owner, owner_n;
    logic         pref, pref_n;

    logic         win0, win1, take;
    logic         sel_right;
    logic [W-1:0] sel_value, sel_amount, sel_count;

    // pref names the requester that wins a tie
    assign win0 = req0_valid && (!pref || !req1_valid);
    assign win1 = req1_valid && (pref || !req0_valid);

    assign req0_ready = (state == IDLE) && win0;
    assign req1_ready = (state == IDLE) && win1;
    assign take = req0_ready || req1_ready;

    assign sel_right  = win1 ? req1_right  : req0_right;
    assign sel_value  = win1 ? req1_value  : req0_value;
    assign sel_amount = win1 ? req1_amount : req0_amount;
    assign sel_count  = (sel_amount > WMAX) ? WMAX : sel_amount;

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign res_value = acc;
    assign res_owner = owner;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        count_n = count;
        dir_n   = dir;
        owner_n = owner;
        pref_n  = pref;
        unique case (state)
            IDLE: begin
                if (take) begin
                    dir_n   = sel_right;
                    owner_n = win1;
`ifdef SHIFT_SCHEDULER_BARREL_EN
                    acc_n   = sel_right ? (sel_value >> sel_count)
                                        : (sel_value << sel_count);
                    count_n = '0;
                    state_n = DONE;
`else
                    acc_n   = sel_value;
                    count_n = sel_count;
                    state_n = (sel_count == '0) ? DONE : SHIFT;
`endif
                end
            end
            SHIFT: begin
                acc_n   = dir ? (acc >> 1) : (acc << 1);
                count_n = count - ONE;
                if (count == ONE) state_n = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_n = IDLE;
                    pref_n  = ~owner;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            dir   <= 1'b0;
            owner <= 1'b0;
            pref  <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            count <= count_n;
            dir   <= dir_n;
            owner <= owner_n;
            pref  <= pref_n;
        end
    end
endmodule

// File: tb/tb_shift_scheduler.sv
// tb_shift_scheduler: vector table plus corner sequences, scoreboarded results.
// A cycle model predicts grants, busy and res_valid timing every cycle.
module tb_shift_scheduler;
    localparam int W = 12;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req0_right = 1'b0;
    logic         req1_valid = 1'b0, req1_right = 1'b0;
    logic [W-1:0] req0_value = '0, req0_amount = '0;
    logic [W-1:0] req1_value = '0, req1_amount = '0;
    logic         req0_ready, req1_ready;
    logic         res_valid, res_owner, busy;
    logic         res_ready = 1'b1;
    logic [W-1:0] res_value;

    shift_scheduler #(.MemoryElementWidth(W)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_value(req0_value), .req0_amount(req0_amount),
        .req0_right(req0_right),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_value(req1_value), .req1_amount(req1_amount),
        .req1_right(req1_right),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_value(res_value), .res_owner(res_owner), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         right;
        logic [W-1:0] value;
        logic [W-1:0] amount;
        logic [W-1:0] expv;
    } vec_t;

    typedef struct {
        logic [W-1:0] value;
        logic         owner;
    } res_t;

    vec_t tbl[12];
    res_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic         m_busy = 1'b0, m_done = 1'b0, m_pref = 1'b0;
    int           m_rem = 0;
    logic [W-1:0] exp_pend[2];
    logic         acc_flag[2];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state describes the DUT after the coming rising edge
    always @(negedge clock) begin : mon
        logic         er0, er1;
        logic [W-1:0] amt;
        res_t         r;
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_pref = 1'b0;
            m_rem  = 0;
            sb.delete();
        end else begin
            er0 = !m_busy && req0_valid && (!m_pref || !req1_valid);
            er1 = !m_busy && req1_valid && (m_pref || !req0_valid);
            chk("req0_ready", {31'b0, req0_ready}, {31'b0, er0});
            chk("req1_ready", {31'b0, req1_ready}, {31'b0, er1});
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("res_valid", {31'b0, res_valid}, {31'b0, m_done});
            if (m_done) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    chk("res_value", {20'b0, res_value}, {20'b0, sb[0].value});
                    chk("res_owner", {31'b0, res_owner}, {31'b0, sb[0].owner});
                end
            end
            if (er0 || er1) begin
                r.value = exp_pend[er1];
                r.owner = er1;
                sb.push_back(r);
                acc_flag[er1] = 1'b1;
                amt = er1 ? req1_amount : req0_amount;
`ifdef SHIFT_SCHEDULER_BARREL_EN
                m_rem = 0;
`else
                m_rem = (amt > W) ? W : int'(amt);
`endif
                m_busy = 1'b1;
                m_done = (m_rem == 0);
            end else if (m_busy && !m_done) begin
                m_rem--;
                if (m_rem == 0) m_done = 1'b1;
            end else if (m_done && res_ready) begin
                if (sb.size() > 0) begin
                    r = sb.pop_front();
                    m_pref = ~r.owner;
                end
                m_busy = 1'b0;
                m_done = 1'b0;
            end
        end
    end

    task automatic drive(input int idx, input logic r, input logic [W-1:0] v,
                         input logic [W-1:0] a, input logic [W-1:0] e);
        exp_pend[idx] = e;
        if (idx == 0) begin
            req0_right = r; req0_value = v; req0_amount = a; req0_valid = 1'b1;
        end else begin
            req1_right = r; req1_value = v; req1_amount = a; req1_valid = 1'b1;
        end
    endtask

    task automatic wait_accept(input int idx);
        int k = 0;
        do begin
            @(posedge clock); #2;
            k++;
        end while (!acc_flag[idx] && k < 100);
        chk("accept_timeout", {31'b0, acc_flag[idx]}, 32'd1);
        acc_flag[idx] = 1'b0;
        if (idx == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (m_busy && k < 100) begin
            @(posedge clock); #2;
            k++;
        end
        chk("idle_timeout", {31'b0, m_busy}, 32'd0);
    endtask

    initial begin
        acc_flag[0] = 1'b0;
        acc_flag[1] = 1'b0;
        tbl[0]  = '{1'b0, 12'h001, 12'd1,    12'h002};
        tbl[1]  = '{1'b0, 12'h00F, 12'd4,    12'h0F0};
        tbl[2]  = '{1'b1, 12'h800, 12'd11,   12'h001};
        tbl[3]  = '{1'b0, 12'hFFF, 12'd12,   12'h000};
        tbl[4]  = '{1'b0, 12'hFFF, 12'd4095, 12'h000};
        tbl[5]  = '{1'b0, 12'hA5A, 12'd0,    12'hA5A};
        tbl[6]  = '{1'b1, 12'hA5A, 12'd4,    12'h0A5};
        tbl[7]  = '{1'b0, 12'hA5A, 12'd4,    12'h5A0};
        tbl[8]  = '{1'b1, 12'hFFF, 12'd13,   12'h000};
        tbl[9]  = '{1'b1, 12'h123, 12'd1,    12'h091};
        tbl[10] = '{1'b0, 12'h801, 12'd11,   12'h800};
        tbl[11] = '{1'b1, 12'h7FF, 12'd3,    12'h0FF};

        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_res_value", {20'b0, res_value}, 32'd0);
        chk("rst_res_owner", {31'b0, res_owner}, 32'd0);

        // both valid straight after reset: requester 0 first
        drive(0, 1'b0, 12'h00F, 12'd4, 12'h0F0);
        drive(1, 1'b1, 12'h800, 12'd11, 12'h001);
        wait_accept(0);
        wait_accept(1);
        wait_idle();

        for (int i = 0; i < 12; i++) begin
            drive(i % 2, tbl[i].right, tbl[i].value, tbl[i].amount, tbl[i].expv);
            wait_accept(i % 2);
            wait_idle();
        end

        // stalled result with req1 waiting
        res_ready = 1'b0;
        drive(0, 1'b0, 12'h003, 12'd2, 12'h00C);
        wait_accept(0);
        drive(1, 1'b0, 12'h001, 12'd3, 12'h008);
        for (int k = 0; k < 100 && !m_done; k++) begin
            @(posedge clock); #2;
        end
        chk("done_reached", {31'b0, m_done}, 32'd1);
        repeat (5) @(posedge clock);
        #2 res_ready = 1'b1;
        wait_accept(1);
        wait_idle();

        // leave requester 1 preferred, then reset mid-operation
        drive(0, 1'b0, 12'h001, 12'd1, 12'h002);
        wait_accept(0);
        wait_idle();
        res_ready = 1'b0;
        drive(0, 1'b0, 12'h0FF, 12'd8, 12'hF00);
        wait_accept(0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
        res_ready = 1'b1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("mid_rst_res_value", {20'b0, res_value}, 32'd0);
        repeat (10) @(posedge clock);
        #2;
        chk("mid_rst_sb", sb.size(), 32'd0);

        // preference back to requester 0
        drive(0, 1'b0, 12'h00F, 12'd4, 12'h0F0);
        drive(1, 1'b1, 12'h800, 12'd11, 12'h001);
        wait_accept(0);
        wait_accept(1);
        wait_idle();
        repeat (2) @(posedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
